// File: rtl/f_pc_sequencer_pkg.sv
// f_pc_sequencer_pkg: fetch-address constants and PC-sequencer FSM encodings
package f_pc_sequencer_pkg;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
   localparam logic [31:0] IM_BASE  = 32'h0000_3000;
   localparam logic [31:0] IM_SIZE  = 32'h0000_3000;
   typedef enum logic [1:0] {
      FPC_RUN   = 2'd0,
      FPC_HOLD  = 2'd1,
      FPC_REDIR = 2'd2
   } fpc_state_e;
endpackage

// File: rtl/f_pc_sequencer_stall_counter.sv
// fpc_stall_counter: saturating stall-run counter with watchdog compare
module fpc_stall_counter #(
   parameter int unsigned W = 8,
   parameter logic [W-1:0] LIMIT = W'(200)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         timeout
);
   // any cycle that is not a held stall ends the run
   always_ff @(posedge clk)
      cnt <= (!reset || !inc) ? '0 : cnt + {{(W-1){1'b0}}, ~&cnt};
   assign timeout = cnt >= LIMIT;
endmodule

// File: rtl/f_pc_sequencer.sv
// f_pc_sequencer: F-stage PC register with stall hold, exception/ERET redirect,
// delay-slot tracking, fetch AdEL detection and a stall-run watchdog
module f_pc_sequencer
   import f_pc_sequencer_pkg::*;
#(
   parameter int unsigned  STALL_W     = 8,
   parameter logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(200)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic [31:0]        npc,
   input  logic               D_is_jump,
   input  logic               exc_req,
   input  logic               eret,
   input  logic [31:0]        epc,
   output logic [31:0]        F_PC,
   output logic               F_BD,
   output logic               F_excAdEL,
   output logic [1:0]         state_o,
   output logic [STALL_W-1:0] stall_cnt,
   output logic               stall_timeout
);
   fpc_state_e state, next_state;
   logic redir, hold;
   localparam logic [32:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
   assign redir = exc_req | eret;
   assign hold  = stall & ~redir;
   always_ff @(posedge clk)
      state <= !reset ? FPC_RUN : next_state;
   always_comb
      next_state = redir ? FPC_REDIR : stall ? FPC_HOLD : FPC_RUN;
   always_comb
      state_o = state;
   always_ff @(posedge clk) begin
      if (!reset) begin
         F_PC <= RESET_PC;
         F_BD <= 1'b0;
      end else if (redir) begin
         F_PC <= exc_req ? EXC_VEC : epc;
         F_BD <= 1'b0;
      end else if (!stall) begin
         F_PC <= npc;
         F_BD <= D_is_jump;
      end
   end
   assign F_excAdEL = (|F_PC[1:0]) | (F_PC < IM_BASE) | ({1'b0, F_PC} >= IM_END);
   fpc_stall_counter #(.W(STALL_W), .LIMIT(STALL_LIMIT)) u_stall_counter (
      .clk     (clk),
      .reset   (reset),
      .inc     (hold),
      .cnt     (stall_cnt),
      .timeout (stall_timeout)
   );
endmodule

// File: tb/tb_f_pc_sequencer.sv
// tb_f_pc_sequencer: directed self-checking bench for f_pc_sequencer
module tb_f_pc_sequencer;
   logic        clk = 1'b0;
   logic        reset, stall, D_is_jump, exc_req, eret;
   logic [31:0] npc, epc;
   logic [31:0] F_PC;
   logic        F_BD, F_excAdEL, stall_timeout;
   logic [1:0]  state_o;
   logic [7:0]  stall_cnt;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   f_pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .npc           (npc),
      .D_is_jump     (D_is_jump),
      .exc_req       (exc_req),
      .eret          (eret),
      .epc           (epc),
      .F_PC          (F_PC),
      .F_BD          (F_BD),
      .F_excAdEL     (F_excAdEL),
      .state_o       (state_o),
      .stall_cnt     (stall_cnt),
      .stall_timeout (stall_timeout)
   );
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   initial begin
      reset = 1'b0; stall = 1'b0; D_is_jump = 1'b0; exc_req = 1'b0; eret = 1'b0;
      npc = 32'h0; epc = 32'h0;
      cyc(); cyc();
      chk("rst_pc", F_PC, 32'h3000);
      chk("rst_bd", F_BD, 0);
      chk("rst_state", state_o, 0);
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_adel", F_excAdEL, 0);
      chk("rst_to", stall_timeout, 0);
      reset = 1'b1; npc = 32'h3004;
      cyc();
      chk("adv1_pc", F_PC, 32'h3004);
      chk("adv1_state", state_o, 0);
      npc = 32'h3008;
      cyc();
      chk("adv2_pc", F_PC, 32'h3008);
      chk("adv2_bd", F_BD, 0);
      chk("adv2_adel", F_excAdEL, 0);
      stall = 1'b1; npc = 32'h300C;
      cyc();
      chk("st1_pc", F_PC, 32'h3008);
      chk("st1_cnt", stall_cnt, 1);
      chk("st1_state", state_o, 1);
      cyc();
      chk("st2_cnt", stall_cnt, 2);
      cyc();
      chk("st3_pc", F_PC, 32'h3008);
      chk("st3_cnt", stall_cnt, 3);
      chk("st3_state", state_o, 1);
      stall = 1'b0;
      cyc();
      chk("rel_pc", F_PC, 32'h300C);
      chk("rel_cnt", stall_cnt, 0);
      chk("rel_state", state_o, 0);
      D_is_jump = 1'b1; npc = 32'h3010;
      cyc();
      chk("br_pc", F_PC, 32'h3010);
      chk("br_bd", F_BD, 1);
      D_is_jump = 1'b0; npc = 32'h3040;
      cyc();
      chk("tgt_pc", F_PC, 32'h3040);
      chk("tgt_bd", F_BD, 0);
      D_is_jump = 1'b1; npc = 32'h3044;
      cyc();
      chk("br2_bd", F_BD, 1);
      stall = 1'b1; D_is_jump = 1'b0; npc = 32'h3080;
      cyc();
      chk("hold_bd", F_BD, 1);
      chk("hold_pc", F_PC, 32'h3044);
      exc_req = 1'b1; eret = 1'b1; epc = 32'h3100;
      cyc();
      chk("exc_pc", F_PC, 32'h4180);
      chk("exc_bd", F_BD, 0);
      chk("exc_state", state_o, 2);
      chk("exc_cnt", stall_cnt, 0);
      exc_req = 1'b0; eret = 1'b0; stall = 1'b0; npc = 32'h4184;
      cyc();
      chk("post_exc_state", state_o, 0);
      chk("post_exc_pc", F_PC, 32'h4184);
      eret = 1'b1; epc = 32'h3002;
      cyc();
      chk("eret1_pc", F_PC, 32'h3002);
      chk("eret1_state", state_o, 2);
      chk("eret1_adel", F_excAdEL, 1);
      epc = 32'h2FFC;
      cyc();
      chk("eret2_adel", F_excAdEL, 1);
      epc = 32'h5FFC;
      cyc();
      chk("eret3_adel", F_excAdEL, 0);
      epc = 32'h6000;
      cyc();
      chk("eret4_adel", F_excAdEL, 1);
      eret = 1'b0; stall = 1'b1;
      cyc();
      chk("redir_hold_state", state_o, 1);
      chk("redir_hold_pc", F_PC, 32'h6000);
      chk("redir_hold_cnt", stall_cnt, 1);
      stall = 1'b0; npc = 32'h3000;
      cyc();
      chk("pre_long_cnt", stall_cnt, 0);
      stall = 1'b1;
      for (int i = 1; i <= 260; i++) begin
         cyc();
         if (i == 199) chk("to_199", stall_timeout, 0);
         if (i == 200) begin
            chk("to_200", stall_timeout, 1);
            chk("cnt_200", stall_cnt, 200);
         end
         if (i == 255) chk("cnt_255", stall_cnt, 255);
      end
      chk("sat_cnt", stall_cnt, 255);
      chk("sat_to", stall_timeout, 1);
      chk("sat_pc", F_PC, 32'h3000);
      reset = 1'b0;
      cyc();
      chk("mid_rst_pc", F_PC, 32'h3000);
      chk("mid_rst_cnt", stall_cnt, 0);
      chk("mid_rst_to", stall_timeout, 0);
      chk("mid_rst_state", state_o, 0);
      reset = 1'b1; stall = 1'b1;
      cyc(); cyc();
      chk("rerun_cnt", stall_cnt, 2);
      stall = 1'b0; npc = 32'h3004;
      cyc();
      chk("rerun_pc", F_PC, 32'h3004);
      chk("rerun_cnt0", stall_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/f_pc_sequencer.md
Name: f_pc_sequencer

Overview:
- F-stage program-counter controller for the 5-stage MIPS pipeline.
- Owns the PC register and decides each cycle whether to advance to the D-stage next-PC, hold for a hazard stall, or redirect to the exception vector or EPC.
- Tracks delay-slot status of the fetched instruction and flags fetch-address exceptions (AdEL).
- Keeps a stall-run counter with a watchdog flag for debug.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VEC, 32'h0000_4180, exception handler entry address
IM_BASE, 32'h0000_3000, lowest legal instruction address
IM_SIZE, 32'h0000_3000, legal fetch window size in bytes
STALL_W, 8, width of the stall-run counter
STALL_LIMIT, 8'd200, consecutive stall cycles that raise stall_timeout

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
stall  in  1  hazard-unit stall request for F/D
npc  in  32  next PC from the D-stage next-PC logic
D_is_jump  in  1  D-stage instruction is a branch or jump (its successor is a delay slot)
exc_req  in  1  M-stage exception/interrupt taken
eret  in  1  ERET taken
epc  in  32  return address for ERET
F_PC  out  32  current fetch address
F_BD  out  1  fetched instruction is in a delay slot
F_excAdEL  out  1  fetch address misaligned or out of window
state_o  out  2  FSM state (RUN=0, HOLD=1, REDIR=2)
stall_cnt  out  STALL_W  length of the current stall run, saturating
stall_timeout  out  1  stall_cnt >= STALL_LIMIT

Behaviour:
- Reset (reset==0 at a clk edge):
  - F_PC=RESET_PC, F_BD=0, state=RUN, stall_cnt=0.
  - Reset overrides every other input.
- Per-edge priority, highest first: reset > exc_req > eret > stall > advance.
  - exc_req: F_PC<=EXC_VEC, F_BD<=0, stall_cnt<=0, state<=REDIR. Applies even if stall=1 or eret=1.
  - eret (no exc_req): F_PC<=epc, F_BD<=0, stall_cnt<=0, state<=REDIR. Applies even if stall=1.
  - stall: F_PC and F_BD hold; state<=HOLD; stall_cnt<=stall_cnt+1, saturating at all-ones (no wrap).
  - advance: F_PC<=npc, F_BD<=D_is_jump, stall_cnt<=0, state<=RUN.
- FSM:
  - RUN→HOLD on stall.
  - HOLD→HOLD while stall; HOLD→RUN on advance.
  - Any state→REDIR on exc_req/eret.
  - REDIR lasts exactly one cycle, then goes to RUN or HOLD by the same rules. REDIR does not block stall.
- F_BD semantics: set only when advancing past a branch or jump. Cleared by any redirect. Retained unchanged through HOLD.
- F_excAdEL (combinational from registered F_PC) = (F_PC[1:0]!=0) | (F_PC<IM_BASE) | (F_PC>=IM_BASE+IM_SIZE).
  - Compare as unsigned 32-bit.
  - IM_BASE+IM_SIZE is computed in 33 bits, so no wrap.
- stall_timeout is combinational from stall_cnt. It clears the cycle after the run ends.
- Latency: a new npc/epc/vector is visible on F_PC one cycle after the edge that samples it. No combinational path from any input to F_PC.
- A stalled redirect to a misaligned epc is legal. F_excAdEL reports it the following cycle; the block never self-corrects the PC.
- Reset asserted mid-stall or mid-REDIR: takes effect at that edge, no residue.

Decomposition:
- Shared def.v holds:
  - reset/vector constants (RESET_PC, EXC_VEC, IM_BASE, IM_SIZE);
  - FSM state encodings FPC_RUN, FPC_HOLD, FPC_REDIR.
- One natural sub-module: fpc_stall_counter (saturating counter plus limit compare).
- The AdEL check stays inline.

Test Plan:
- Reset release, stall=0, npc=F_PC+4 each cycle → F_PC 0x3000, 0x3004, 0x3008; F_BD=0; state RUN; F_excAdEL=0.
- Branch in D (D_is_jump=1, npc=0x3010) then advance with npc=0x3040 → F_BD=1 on 0x3010, F_BD=0 on 0x3040.
- stall held 3 cycles with F_PC=0x3008 → F_PC stays 0x3008; stall_cnt 1,2,3; state HOLD; then release → stall_cnt=0, state RUN.
- exc_req=1 together with stall=1 and eret=1 → next F_PC=0x4180, F_BD=0, state REDIR for 1 cycle, stall_cnt=0.
- eret with epc=0x3002, then eret with epc=0x2FFC → F_excAdEL=1 both times; epc=0x5FFC → 0; epc=0x6000 → 1.
- stall held 260 cycles with STALL_W=8, then assert reset=0 mid-run:
  - stall_timeout rises at cycle 200;
  - stall_cnt saturates at 255;
  - reset gives F_PC=0x3000, stall_cnt=0, stall_timeout=0.
